// File: rtl/sram_port_arbiter.sv
// Read-port arbiter between the APB SRAM controller and the tile scanner for a
// two-port tile-map RAM; writes pass straight through, reads return after one cycle.
module sram_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          PCLK,
  input  logic          PRESERN,
  input  logic          cpu_wen,
  input  logic          cpu_ren,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [AW-1:0] cpu_raddr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wd,
  output logic          ram_ren,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rd
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DISP} owner_t;

  owner_t          owner_d, owner_q;
  logic [CW-1:0]   wait_cnt_d, wait_cnt_q;
  logic            force_slot;
  logic            bypass_d, bypass_q;
  logic [DW-1:0]   byp_data_q;
  logic [DW-1:0]   cpu_hold_q, disp_hold_q;
  logic [DW-1:0]   ret_word;

  assign ram_wen   = PRESERN & cpu_wen;
  assign ram_waddr = PRESERN ? cpu_waddr : '0;
  assign ram_wd    = PRESERN ? cpu_wd : '0;

  // Scanner wins over the CPU only once it has been denied MAX_WAIT cycles in a row.
  always_comb begin
    owner_d    = OWN_NONE;
    force_slot = disp_req && (wait_cnt_q == CW'(MAX_WAIT));
    if (PRESERN) begin
      if (force_slot)    owner_d = OWN_DISP;
      else if (cpu_ren)  owner_d = OWN_CPU;
      else if (disp_req) owner_d = OWN_DISP;
    end
  end

  assign disp_gnt  = (owner_d == OWN_DISP);
  assign ram_ren   = (owner_d != OWN_NONE);
  assign ram_raddr = (owner_d == OWN_DISP) ? disp_addr : cpu_raddr;

  assign bypass_d  = ram_wen && ram_ren && (ram_waddr == ram_raddr);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!disp_req || disp_gnt)
      wait_cnt_d = '0;
    else if (wait_cnt_q != CW'(MAX_WAIT))
      wait_cnt_d = wait_cnt_q + CW'(1);
  end

  // RAM returns old data on a same-address collision; the saved write word overrides it.
  assign ret_word    = bypass_q ? byp_data_q : ram_rd;
  assign cpu_rd      = (owner_q == OWN_CPU) ? ret_word : cpu_hold_q;
  assign disp_rvalid = (owner_q == OWN_DISP);
  assign disp_rdata  = disp_rvalid ? ret_word : disp_hold_q;

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      owner_q     <= OWN_NONE;
      wait_cnt_q  <= '0;
      bypass_q    <= 1'b0;
      byp_data_q  <= '0;
      cpu_hold_q  <= '0;
      disp_hold_q <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      bypass_q   <= bypass_d;
      byp_data_q <= ram_wd;
      if (owner_q == OWN_CPU)  cpu_hold_q  <= ret_word;
      if (owner_q == OWN_DISP) disp_hold_q <= ret_word;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle registered-read RAM.
module tb_sram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESERN;
  logic          cpu_wen, cpu_ren;
  logic [AW-1:0] cpu_waddr, cpu_raddr;
  logic [DW-1:0] cpu_wd, cpu_rd;
  logic          disp_req, disp_gnt, disp_rvalid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          ram_wen, ram_ren;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wd, ram_rd;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 PCLK = ~PCLK;

  sram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN),
    .cpu_wen(cpu_wen), .cpu_ren(cpu_ren), .cpu_waddr(cpu_waddr), .cpu_raddr(cpu_raddr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wd(ram_wd),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rd(ram_rd)
  );

  // Read-before-write RAM: a same-address read returns the old word.
  always @(posedge PCLK) begin
    if (ram_wen) mem[ram_waddr] <= ram_wd;
    if (ram_ren) ram_rd <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    cpu_wen = 0; cpu_ren = 0; disp_req = 0;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[10'h000] = 32'h0000_0011;
    mem[10'h020] = 32'h0BAD_F00D;
    mem[10'h3FF] = 32'hA5A5_A5A5;
    for (int i = 0; i < 10; i++) mem[10'h040 + i] = 32'h0000_1000 + i;
    ram_rd = '0;

    // reset with requests pending
    PRESERN = 0; cpu_wen = 1; cpu_ren = 1; disp_req = 1;
    cpu_waddr = 10'h001; cpu_raddr = 10'h002; cpu_wd = 32'hFFFF_FFFF; disp_addr = 10'h000;
    next_cycle();
    next_cycle();
    chk("rst_cpu_rd", cpu_rd, 0);
    chk("rst_rvalid", {31'b0, disp_rvalid}, 0);
    chk("rst_rdata", disp_rdata, 0);
    chk("rst_ram_wen", {31'b0, ram_wen}, 0);
    chk("rst_ram_ren", {31'b0, ram_ren}, 0);

    PRESERN = 1; cpu_wen = 0; cpu_ren = 0;
    @(negedge PCLK);
    chk("rel_gnt", {31'b0, disp_gnt}, 1);
    next_cycle();
    disp_req = 0;
    chk("rel_rvalid", {31'b0, disp_rvalid}, 1);
    chk("rel_rdata", disp_rdata, 32'h0000_0011);

    // write then read
    cpu_wen = 1; cpu_waddr = 10'h005; cpu_wd = 32'hDEAD_BEEF;
    @(negedge PCLK);
    chk("wr_wen", {31'b0, ram_wen}, 1);
    chk("wr_waddr", {22'b0, ram_waddr}, 32'h005);
    chk("wr_wd", ram_wd, 32'hDEAD_BEEF);
    next_cycle();
    cpu_wen = 0; cpu_ren = 1; cpu_raddr = 10'h005;
    @(negedge PCLK);
    chk("rd_ren", {31'b0, ram_ren}, 1);
    chk("rd_raddr", {22'b0, ram_raddr}, 32'h005);
    next_cycle();
    cpu_ren = 0;
    chk("rd_data", cpu_rd, 32'hDEAD_BEEF);
    next_cycle();
    chk("rd_hold", cpu_rd, 32'hDEAD_BEEF);

    // same-cycle write/read collision
    cpu_wen = 1; cpu_ren = 1; cpu_waddr = 10'h010; cpu_raddr = 10'h010; cpu_wd = 32'h1234_5678;
    next_cycle();
    idle();
    chk("byp_data", cpu_rd, 32'h1234_5678);

    // different addresses: no bypass
    cpu_wen = 1; cpu_ren = 1; cpu_waddr = 10'h021; cpu_raddr = 10'h020; cpu_wd = 32'h5555_AAAA;
    next_cycle();
    idle();
    chk("nobyp_data", cpu_rd, 32'h0BAD_F00D);

    // idle-port scanner read
    disp_req = 1; disp_addr = 10'h3FF;
    @(negedge PCLK);
    chk("disp_gnt", {31'b0, disp_gnt}, 1);
    chk("disp_raddr", {22'b0, ram_raddr}, 32'h3FF);
    next_cycle();
    disp_req = 0;
    chk("disp_rvalid", {31'b0, disp_rvalid}, 1);
    chk("disp_rdata", disp_rdata, 32'hA5A5_A5A5);
    chk("disp_cpu_hold", cpu_rd, 32'h0BAD_F00D);
    next_cycle();
    chk("disp_rvalid_1cyc", {31'b0, disp_rvalid}, 0);

    // starvation guard: CPU reads every cycle, scanner forced on 5th request cycle
    disp_req = 1; disp_addr = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      cpu_ren = 1; cpu_raddr = 10'h040 + i;
      @(negedge PCLK);
      chk($sformatf("starve_gnt%0d", i), {31'b0, disp_gnt}, (i == 4) ? 1 : 0);
      next_cycle();
      if (i == 4) begin
        disp_req = 0;
        chk("starve_rvalid", {31'b0, disp_rvalid}, 1);
        chk("starve_rdata", disp_rdata, 32'hA5A5_A5A5);
        chk("starve_cpu_hold", cpu_rd, 32'h0000_1003);
      end else begin
        chk($sformatf("starve_cpu%0d", i), cpu_rd, 32'h0000_1000 + i);
      end
    end
    idle();
    next_cycle();

    // reset clears a partially accumulated wait count
    cpu_ren = 1; cpu_raddr = 10'h040; disp_req = 1; disp_addr = 10'h3FF;
    next_cycle();
    next_cycle();
    PRESERN = 0;
    next_cycle();
    PRESERN = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk($sformatf("rstwait_gnt%0d", i), {31'b0, disp_gnt}, (i == 4) ? 1 : 0);
      next_cycle();
    end
    idle();
    next_cycle();

    // reset right after a scanner grant discards the return
    disp_req = 1; disp_addr = 10'h3FF;
    @(negedge PCLK);
    chk("midrst_gnt", {31'b0, disp_gnt}, 1);
    PRESERN = 0;
    next_cycle();
    chk("midrst_rvalid", {31'b0, disp_rvalid}, 0);
    chk("midrst_cpu_rd", cpu_rd, 0);
    disp_req = 0;
    PRESERN = 1;
    next_cycle();
    chk("midrst_rvalid2", {31'b0, disp_rvalid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
